mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Memory-access stage of the five-stage pipeline. Holds the EX/MEM pipeline
// register, waits for the data SRAM to return load data, extracts and
// extends the addressed byte/half/word, and drives the write-back and
// forwarding buses.
//
// Ports
//   clk               rising-edge clock
//   rst               asynchronous, active-high reset
//   stall             stall vector; bit 3 = EX/MEM register, bit 4 = MEM/WB
//   ex_to_mem_bus     {mem_op, pc, data_ram_en, data_ram_wen, sel_rf_res,
//                      rf_we, rf_waddr, ex_result}
//   data_sram_rdata   data SRAM read data
//   data_sram_data_ok read data valid this cycle
//   mem_to_wb_bus     {pc, rf_we, rf_waddr, rf_wdata}
//   mem_to_rf_bus     {rf_we, rf_waddr, rf_wdata} forwarding bus
//   stallreq_for_mem  asks the stall controller to freeze stages 0-4
// ---------------------------------------------------------------------------
`ifndef EX_TO_MEM_WD
`define EX_TO_MEM_WD 81
`endif
`ifndef MEM_TO_WB_WD
`define MEM_TO_WB_WD 70
`endif
`ifndef MEM_TO_RF_WD
`define MEM_TO_RF_WD 38
`endif
`ifndef StallBus
`define StallBus 6
`endif
`ifndef Stop
`define Stop 1'b1
`endif
`ifndef NoStop
`define NoStop 1'b0
`endif

module mem_stage (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [`StallBus-1:0]     stall,
   input  logic [`EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   input  logic [31:0]              data_sram_rdata,
   input  logic                     data_sram_data_ok,
   output logic [`MEM_TO_WB_WD-1:0] mem_to_wb_bus,
   output logic [`MEM_TO_RF_WD-1:0] mem_to_rf_bus,
   output logic                     stallreq_for_mem
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [`EX_TO_MEM_WD-1:0] ex_mem_q;
   logic [31:0]              buf_q;
   logic                     capture;

   logic [4:0]  mem_op;
   logic [31:0] pc;
   logic        data_ram_en;
   logic [3:0]  data_ram_wen;
   logic        sel_rf_res;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] ex_result;
   logic        is_load;
   logic [31:0] load_word;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data;
   logic [31:0] rf_wdata;
   logic        unused_stall;

   assign unused_stall = ^{stall[5], stall[2:0]};

   // EX/MEM pipeline register. When EX is frozen but MEM/WB keeps moving,
   // a bubble is inserted so the instruction still in MEM is not written
   // back twice; when both are frozen the register simply holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_mem_q <= '0;
      end else if (stall[3] == `Stop && stall[4] == `NoStop) begin
         ex_mem_q <= '0;
      end else if (stall[3] == `NoStop) begin
         ex_mem_q <= ex_to_mem_bus;
      end
   end

   assign {mem_op, pc, data_ram_en, data_ram_wen, sel_rf_res,
           rf_we, rf_waddr, ex_result} = ex_mem_q;

   assign is_load = data_ram_en && (data_ram_wen == 4'b0000) && (mem_op != 5'b00000);

   // Load-data buffer. The SRAM only presents rdata for the data_ok cycle,
   // so if WB is frozen at that moment the word is kept here until the
   // pipeline moves on.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q <= '0;
      end else if (capture) begin
         buf_q <= data_sram_rdata;
      end
   end

   // Load-wait FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and stall-request logic. The stall request is raised in the
   // very cycle the load is seen without data so the controller freezes the
   // pipeline before the instruction moves on. data_ok is only meaningful
   // for a load in IDLE or while waiting; anywhere else it is ignored.
   always_comb begin
      state_d          = state_q;
      capture          = 1'b0;
      stallreq_for_mem = 1'b0;
      case (state_q)
         IDLE: begin
            if (is_load) begin
               if (data_sram_data_ok) begin
                  capture = 1'b1;
                  state_d = (stall[4] == `Stop) ? HOLD : IDLE;
               end else begin
                  stallreq_for_mem = 1'b1;
                  state_d          = WAIT;
               end
            end
         end
         WAIT: begin
            if (data_sram_data_ok) begin
               capture = 1'b1;
               state_d = (stall[4] == `Stop) ? HOLD : IDLE;
            end else begin
               stallreq_for_mem = 1'b1;
            end
         end
         HOLD: begin
            if (stall[4] == `NoStop) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Byte/half/word extraction. Once the word has been parked in the buffer
   // it is the only valid source; the SRAM may already show something else.
   // The halfword is chosen by address bit 1 alone.
   always_comb begin
      load_word = (state_q == HOLD) ? buf_q : data_sram_rdata;
      case (ex_result[1:0])
         2'd0:    byte_sel = load_word[7:0];
         2'd1:    byte_sel = load_word[15:8];
         2'd2:    byte_sel = load_word[23:16];
         default: byte_sel = load_word[31:24];
      endcase
      half_sel = ex_result[1] ? load_word[31:16] : load_word[15:0];
      if (mem_op[4]) begin
         load_data = {{24{byte_sel[7]}}, byte_sel};
      end else if (mem_op[3]) begin
         load_data = {24'b0, byte_sel};
      end else if (mem_op[2]) begin
         load_data = {{16{half_sel[15]}}, half_sel};
      end else if (mem_op[1]) begin
         load_data = {16'b0, half_sel};
      end else begin
         load_data = load_word;
      end
   end

   assign rf_wdata      = sel_rf_res ? load_data : ex_result;
   assign mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
   assign mem_to_rf_bus = {rf_we, rf_waddr, rf_wdata};

endmodule
